// File: rtl/apb_mst_bridge.sv
// apb_mst_bridge: single-outstanding APB4 requester.
// Takes valid/ready commands and runs one APB transfer at a time on a
// 2-slave port. Each result is returned on a valid/ready response channel.
// Optional feature: define APB_MST_TIMEOUT_EN to abort transfers whose
// ACCESS phase stalls for TIMEOUT_CYC wait cycles. With the macro undefined,
// wait states are unbounded and o_rsp_tout is constant 0.
// All outputs come straight from flops, so no input reaches an output
// combinationally.
module apb_mst_bridge #(
  parameter int ADDR_W      = 20,
  parameter int DATA_W      = 16,
  parameter int TIMEOUT_CYC = 255,
  localparam int STRB_W     = DATA_W / 8
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  // command channel
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic              i_cmd_write,
  input  logic [ADDR_W:0]   i_cmd_addr,
  input  logic [DATA_W-1:0] i_cmd_wdata,
  input  logic [STRB_W-1:0] i_cmd_strb,
  // response channel
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [DATA_W-1:0] o_rsp_rdata,
  output logic              o_rsp_err,
  output logic              o_rsp_tout,
  // APB requester port
  output logic [1:0]        o_psel,
  output logic              o_penable,
  output logic [ADDR_W-1:0] o_paddr,
  output logic [DATA_W-1:0] o_pwdata,
  output logic              o_pwrite,
  output logic [STRB_W-1:0] o_pstrb,
  input  logic [DATA_W-1:0] i_prdata,
  input  logic              i_pready,
  input  logic              i_pslverr
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

  state_t r_state, w_state_nxt;

  logic              r_cmd_ready, w_cmd_ready_nxt;
  logic              r_rsp_valid, w_rsp_valid_nxt;
  logic [DATA_W-1:0] r_rsp_rdata, w_rsp_rdata_nxt;
  logic              r_rsp_err,   w_rsp_err_nxt;
  logic [1:0]        r_psel,      w_psel_nxt;
  logic              r_penable,   w_penable_nxt;
  logic [ADDR_W-1:0] r_paddr,     w_paddr_nxt;
  logic [DATA_W-1:0] r_pwdata,    w_pwdata_nxt;
  logic              r_pwrite,    w_pwrite_nxt;
  logic [STRB_W-1:0] r_pstrb,     w_pstrb_nxt;

  logic w_accept;   // command handshake completes on this edge
  logic w_tout;     // ACCESS is being aborted on this edge
  logic w_consume;  // response handshake completes on this edge

  // cmd_ready only goes high in IDLE, so the state check doubles as a guard
  // against accepting while a response is still pending.
  assign w_accept  = (r_state == S_IDLE) && i_cmd_valid && r_cmd_ready;
  assign w_consume = (r_state == S_RESP) && r_rsp_valid && i_rsp_ready;

`ifdef APB_MST_TIMEOUT_EN
  // At least 8 bits, wider if TIMEOUT_CYC needs it.
  localparam int TW = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;

  logic [TW-1:0] r_tcnt;
  logic          r_rsp_tout;

  // The counter holds the number of wait cycles already spent in ACCESS.
  // Expiry is the edge that would make it reach TIMEOUT_CYC. pready=1 on
  // that same edge takes priority, so the transfer completes normally.
  assign w_tout = (r_state == S_ACCESS) && !i_pready &&
                  (r_tcnt == TW'(TIMEOUT_CYC - 1));

  // Wait-cycle counter: cleared while in SETUP (entry to ACCESS), counts ACCESS stalls.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)                              r_tcnt <= '0;
    else if (r_state == S_SETUP)                 r_tcnt <= '0;
    else if (r_state == S_ACCESS && !i_pready)   r_tcnt <= r_tcnt + 1'b1;
  end

  // Timeout flag: set on abort, cleared when the response is consumed.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)     r_rsp_tout <= 1'b0;
    else if (w_tout)    r_rsp_tout <= 1'b1;
    else if (w_consume) r_rsp_tout <= 1'b0;
  end

  assign o_rsp_tout = r_rsp_tout;
`else
  assign w_tout     = 1'b0;
  assign o_rsp_tout = 1'b0;
`endif

  // State register.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= S_IDLE;
    else            r_state <= w_state_nxt;
  end

  // Next-state logic: IDLE -> SETUP -> ACCESS (waits) -> RESP -> IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_accept)             w_state_nxt = S_SETUP;
      S_SETUP:                            w_state_nxt = S_ACCESS;
      S_ACCESS: if (i_pready || w_tout)   w_state_nxt = S_RESP;
      S_RESP:   if (w_consume)            w_state_nxt = S_IDLE;
      default:                            w_state_nxt = S_IDLE;
    endcase
  end

  // Next values of the output registers. Anything not assigned here holds.
  // This is what keeps paddr/pwdata/pwrite alive on an idle bus.
  always_comb begin
    w_cmd_ready_nxt = (w_state_nxt == S_IDLE);
    w_rsp_valid_nxt = r_rsp_valid;
    w_rsp_rdata_nxt = r_rsp_rdata;
    w_rsp_err_nxt   = r_rsp_err;
    w_psel_nxt      = r_psel;
    w_penable_nxt   = r_penable;
    w_paddr_nxt     = r_paddr;
    w_pwdata_nxt    = r_pwdata;
    w_pwrite_nxt    = r_pwrite;
    w_pstrb_nxt     = r_pstrb;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_paddr_nxt  = i_cmd_addr[ADDR_W-1:0];
          w_pwdata_nxt = i_cmd_wdata;
          w_pwrite_nxt = i_cmd_write;
          w_pstrb_nxt  = i_cmd_write ? i_cmd_strb : '0;
          w_psel_nxt   = i_cmd_addr[ADDR_W] ? 2'b10 : 2'b01;
        end
      end
      S_SETUP: begin
        w_penable_nxt = 1'b1;
      end
      S_ACCESS: begin
        // prdata/pslverr are only looked at on a pready=1 edge.
        if (i_pready || w_tout) begin
          w_psel_nxt      = 2'b00;
          w_penable_nxt   = 1'b0;
          w_pstrb_nxt     = '0;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_rdata_nxt = (i_pready && !r_pwrite) ? i_prdata : '0;
          w_rsp_err_nxt   = i_pready ? i_pslverr : 1'b1;
        end
      end
      S_RESP: begin
        if (w_consume) begin
          w_rsp_valid_nxt = 1'b0;
          w_rsp_err_nxt   = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Output registers. Async reset drops psel/penable immediately mid-transfer.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_cmd_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_psel      <= 2'b00;
      r_penable   <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_pwrite    <= 1'b0;
      r_pstrb     <= '0;
    end else begin
      r_cmd_ready <= w_cmd_ready_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
      r_psel      <= w_psel_nxt;
      r_penable   <= w_penable_nxt;
      r_paddr     <= w_paddr_nxt;
      r_pwdata    <= w_pwdata_nxt;
      r_pwrite    <= w_pwrite_nxt;
      r_pstrb     <= w_pstrb_nxt;
    end
  end

  assign o_cmd_ready = r_cmd_ready;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_rdata = r_rsp_rdata;
  assign o_rsp_err   = r_rsp_err;
  assign o_psel      = r_psel;
  assign o_penable   = r_penable;
  assign o_paddr     = r_paddr;
  assign o_pwdata    = r_pwdata;
  assign o_pwrite    = r_pwrite;
  assign o_pstrb     = r_pstrb;

endmodule

// File: doc/apb_mst_bridge.md
Name: apb_mst_bridge

Overview:
APB4 requester that turns single-beat valid/ready commands from the SPI/crypto control path into APB transfers on the 2-slave interconnect port. Drives psel[1:0], penable, paddr[19:0], pwdata[15:0], pwrite and pstrb[1:0]. Honours pready wait states and captures prdata and pslverr. Returns each result on a valid/ready response channel. Only one transfer is outstanding at a time.

Parameters:
ADDR_W, 20, APB address width (paddr).
DATA_W, 16, APB data width; STRB_W = DATA_W/8.
TIMEOUT_CYC, 255, maximum ACCESS cycles before abort (used only with the optional feature).

Ports:
clk  in  1  system clock, rising edge.
reset_n  in  1  asynchronous active-low reset.
cmd_valid  in  1  command request.
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
cmd_write  in  1  1 = write, 0 = read.
cmd_addr  in  ADDR_W+1  bit ADDR_W selects slave (0 -> psel=2'b01, 1 -> psel=2'b10); bits ADDR_W-1:0 -> paddr.
cmd_wdata  in  DATA_W  write data.
cmd_strb  in  STRB_W  write byte strobes.
rsp_valid  out  1  response available.
rsp_ready  in  1  response consumed when rsp_valid & rsp_ready.
rsp_rdata  out  DATA_W  read data; 0 for writes.
rsp_err  out  1  pslverr captured, or timeout.
rsp_tout  out  1  the transfer was aborted by timeout.
psel  out  2  one-hot slave select.
penable  out  1  APB access phase.
paddr  out  ADDR_W  APB address.
pwdata  out  DATA_W  APB write data.
pwrite  out  1  APB direction.
pstrb  out  STRB_W  APB strobes; forced to 0 on reads.
prdata  in  DATA_W  slave read data.
pready  in  1  slave ready.
pslverr  in  1  slave error; valid only when pready=1 in ACCESS.

Behaviour:
- Reset (async, reset_n=0): state IDLE; all outputs 0, including cmd_ready. cmd_ready rises on the first clk edge after reset release.
- All outputs are registered. No combinational path from any input to any output.
- FSM states:
  - IDLE: cmd_ready=1. On an accept edge: latch paddr, pwdata, pwrite, pstrb (0 if read) and psel. Go to SETUP. cmd_ready=0 from the same edge.
  - SETUP: psel!=0, penable=0. Unconditionally go to ACCESS; penable=1.
  - ACCESS: psel and penable held; paddr, pwdata, pwrite and pstrb are stable. At each edge with pready=1: capture rsp_rdata (prdata if read, else 0) and rsp_err=pslverr. Clear psel and penable, set rsp_valid=1, go to RESP. pready=0 means a wait state; stay.
  - RESP: hold rsp_* stable while rsp_ready=0. On rsp_valid & rsp_ready: rsp_valid=0, clear rsp_err and rsp_tout, cmd_ready=1, go to IDLE.
- Latency: with pready=1 on the first ACCESS cycle and command accepted at edge N: psel at N+1, penable at N+2, rsp_valid at N+3, cmd_ready at M+1 where M is the response-consume edge. Each wait state adds 1 cycle.
- Idle bus: paddr, pwdata and pwrite keep their last values after a transfer. pstrb returns to 0.
- pslverr and prdata are ignored whenever pready=0 or the FSM is not in ACCESS.
- Back-to-back transfers: minimum 4 cycles per transfer (IDLE, SETUP, ACCESS, RESP). A command must not be accepted while rsp_valid=1.
- Reset asserted mid-transfer: psel and penable drop to 0 immediately (asynchronously). The transfer is lost and no response is produced.

Optional Feature:
Macro APB_MST_TIMEOUT_EN.
- Defined: an 8+ bit counter clears on entry to ACCESS and increments on each ACCESS cycle with pready=0. When it reaches TIMEOUT_CYC with pready still 0, the block ends the transfer: psel=penable=0, rsp_valid=1, rsp_err=1, rsp_tout=1, rsp_rdata=0, go to RESP. pready=1 on the same edge as expiry wins: normal completion, no timeout.
- Not defined: no counter, wait states are unbounded, and rsp_tout is tied to 0.

Test Plan:
- Write cmd_addr=21'h00123, wdata=16'hBEEF, strb=2'b11, pready=1 -> psel=01, paddr=20'h00123, pwdata=BEEF, pwrite=1, penable on the 2nd cycle, rsp_valid 3 cycles after accept, rsp_err=0, rsp_rdata=0.
- Read cmd_addr=21'h100040, prdata=16'hABCD, 3 wait states -> psel=10, pstrb=00, rsp_valid 6 cycles after accept, rsp_rdata=ABCD.
- Read with pslverr=1 on the pready=1 edge -> rsp_err=1. pslverr=1 with pready=0 -> ignored.
- rsp_ready held 0 for 5 cycles -> rsp_* stable, cmd_ready=0, psel=0. Consume -> cmd_ready=1 the next cycle. Then a back-to-back second command completes correctly.
- reset_n pulled low during ACCESS -> psel, penable, rsp_valid and cmd_ready are 0 asynchronously. After release, one cmd completes normally.
- APB_MST_TIMEOUT_EN, TIMEOUT_CYC=4, pready stuck 0 -> abort after 4 wait cycles with rsp_err=1 and rsp_tout=1. Without the macro -> the transfer waits until pready.
